// File: rtl/dmem_pingpong_pkg.sv
// Shared types and helpers for the dmem ping-pong scheduler.
package dmem_pingpong_pkg;

  localparam int unsigned PERF_W = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BOTH  = 2'd1,
    WFULL = 2'd2,
    SWAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic rd_bank;
    logic wr_acc;
    logic rd_issue;
    logic rd_done;
  } sched_flags_t;

  // Highest in-bank index; reserved as the parking slot for idle write addresses.
  function automatic int unsigned scratch_idx(input int unsigned addr);
    return (32'd1 << (addr - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/dmem_pingpong_perf.sv
// Saturating stall/starve counters for the dmem ping-pong scheduler.
// Only compiled when DMEM_PINGPONG_CTRL_PERF_EN is defined.
`ifdef DMEM_PINGPONG_CTRL_PERF_EN
module dmem_pingpong_perf
  import dmem_pingpong_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_stall,
  input  logic              rd_idle,
  input  logic              frame_swap,
  output logic [PERF_W-1:0] wr_stall_cnt,
  output logic [PERF_W-1:0] rd_starve_cnt
);

  logic seen_frame;

  // Starvation only means something once a first frame has been handed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_frame    <= 1'b0;
      wr_stall_cnt  <= '0;
      rd_starve_cnt <= '0;
    end else begin
      if (frame_swap) begin
        seen_frame <= 1'b1;
      end
      if (wr_stall && (wr_stall_cnt != '1)) begin
        wr_stall_cnt <= wr_stall_cnt + PERF_W'(1);
      end
      if (rd_idle && seen_frame && (rd_starve_cnt != '1)) begin
        rd_starve_cnt <= rd_starve_cnt + PERF_W'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/dmem_pingpong_ctrl.sv
// Ping-pong bank scheduler for the PE data memory: producer fills one bank, consumer drains the other.
// Define DMEM_PINGPONG_CTRL_PERF_EN to build the saturating perf counters.
module dmem_pingpong_ctrl
  import dmem_pingpong_pkg::*;
#(
  parameter int unsigned BITS = 32,
  parameter int unsigned ADDR = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BITS-1:0]   wr_data,
  input  logic              wr_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [BITS-1:0]   rd_data,
  output logic              rd_last,
  output logic              err_ovf,
  output logic [PERF_W-1:0] wr_stall_cnt,
  output logic [PERF_W-1:0] rd_starve_cnt,
  output logic              mem_cen,
  output logic              mem_gwen,
  output logic [ADDR-1:0]   mem_addr_r,
  output logic [ADDR-1:0]   mem_addr_w,
  output logic [BITS-1:0]   mem_data_i,
  input  logic [BITS-1:0]   mem_q
);

  localparam int unsigned     LO_W     = ADDR - 1;
  localparam logic [LO_W-1:0] SCRATCH  = LO_W'(scratch_idx(ADDR));
  localparam logic [LO_W-1:0] LAST_IDX = SCRATCH - LO_W'(1);

  state_t          state;
  state_t          state_nxt;
  sched_flags_t    flags;
  logic            rd_bank;
  logic [LO_W-1:0] wr_ptr;
  logic [LO_W-1:0] rd_ptr;
  logic [LO_W-1:0] rd_len;
  logic [LO_W-1:0] rd_addr_q;
  logic            wr_end;
  logic            rd_avail;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshakes and the memory port drive.
  always_comb begin
    state_nxt      = state;
    flags.rd_bank  = rd_bank;
    flags.wr_acc   = wr_valid && wr_ready;
    flags.rd_done  = rd_valid && rd_ready && rd_last;
    wr_end         = wr_last || (wr_ptr == LAST_IDX);
    rd_avail       = (rd_ptr != rd_len) && ((state == BOTH) || (state == WFULL));
    flags.rd_issue = rd_avail && (!rd_valid || rd_ready);

    unique case (state)
      FILL: begin
        if (flags.wr_acc && wr_end) begin
          state_nxt = SWAP;
        end
      end
      BOTH: begin
        if (flags.wr_acc && wr_end && flags.rd_done) begin
          state_nxt = SWAP;
        end else if (flags.wr_acc && wr_end) begin
          state_nxt = WFULL;
        end else if (flags.rd_done) begin
          state_nxt = FILL;
        end
      end
      WFULL: begin
        if (flags.rd_done) begin
          state_nxt = SWAP;
        end
      end
      SWAP: begin
        state_nxt = BOTH;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase

    // Stalled reads keep the last issued address so mem_q survives write-only cycles.
    mem_gwen   = 1'b1;
    mem_cen    = !(flags.wr_acc || flags.rd_issue);
    mem_addr_r = {flags.rd_bank, (flags.rd_issue ? rd_ptr : rd_addr_q)};
    mem_addr_w = {~flags.rd_bank, (flags.wr_acc ? wr_ptr : SCRATCH)};
    mem_data_i = wr_data;
  end

  assign rd_data = mem_q;

  // Pointers, bank ownership and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_len    <= '0;
      rd_addr_q <= SCRATCH;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      wr_ready <= (state_nxt == FILL) || (state_nxt == BOTH);

      if (state == SWAP) begin
        rd_bank <= ~rd_bank;
        rd_len  <= wr_ptr;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (flags.wr_acc) begin
          wr_ptr <= wr_ptr + LO_W'(1);
        end
        if (flags.rd_issue) begin
          rd_ptr <= rd_ptr + LO_W'(1);
        end
      end

      if (flags.rd_issue) begin
        rd_addr_q <= rd_ptr;
        rd_valid  <= 1'b1;
        rd_last   <= ((rd_ptr + LO_W'(1)) == rd_len);
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end

      // A frame that reaches the scratch slot is cut short and flagged.
      if (flags.wr_acc && !wr_last && (wr_ptr == LAST_IDX)) begin
        err_ovf <= 1'b1;
      end
    end
  end

`ifdef DMEM_PINGPONG_CTRL_PERF_EN
  dmem_pingpong_perf u_perf (
    .clk           (clk),
    .rst           (rst),
    .wr_stall      (wr_valid && !wr_ready),
    .rd_idle       ((state == FILL) || (state == SWAP)),
    .frame_swap    (state == SWAP),
    .wr_stall_cnt  (wr_stall_cnt),
    .rd_starve_cnt (rd_starve_cnt)
  );
`else
  assign wr_stall_cnt  = '0;
  assign rd_starve_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_pingpong_ctrl.sv
// Directed bench for dmem_pingpong_ctrl with a behavioural dmem and a word scoreboard.
module tb_dmem_pingpong_ctrl;

  localparam int BITS    = 32;
  localparam int ADDR    = 9;
  localparam int MAX_LEN = 255;

  typedef struct packed {
    logic [BITS-1:0] data;
    logic            last;
  } word_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [BITS-1:0] wr_data;
  logic            wr_last;
  logic            rd_valid;
  logic            rd_ready;
  logic [BITS-1:0] rd_data;
  logic            rd_last;
  logic            err_ovf;
  logic [15:0]     wr_stall_cnt;
  logic [15:0]     rd_starve_cnt;
  logic            mem_cen;
  logic            mem_gwen;
  logic [ADDR-1:0] mem_addr_r;
  logic [ADDR-1:0] mem_addr_w;
  logic [BITS-1:0] mem_data_i;
  logic [BITS-1:0] mem_q;

  logic [BITS-1:0] mem [512];

  word_t src[$];
  word_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    wcnt = 0;
  int    rd_idx = 0;
  int    frames_done = 0;
  int    wgap = 0;
  int    rgap = 0;
  logic  gap_en = 1'b0;
  logic  w_inframe = 1'b0;
  logic  r_inframe = 1'b0;
  logic  rdy = 1'b1;

  always #5 clk = ~clk;

  dmem_pingpong_ctrl #(.BITS(BITS), .ADDR(ADDR)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .err_ovf       (err_ovf),
    .wr_stall_cnt  (wr_stall_cnt),
    .rd_starve_cnt (rd_starve_cnt),
    .mem_cen       (mem_cen),
    .mem_gwen      (mem_gwen),
    .mem_addr_r    (mem_addr_r),
    .mem_addr_w    (mem_addr_w),
    .mem_data_i    (mem_data_i),
    .mem_q         (mem_q)
  );

  // Dual-address dmem: an enabled cycle reads addr_r and writes addr_w.
  always @(posedge clk) begin
    if (!mem_cen) begin
      mem_q <= mem[mem_addr_r];
      if (mem_gwen) mem[mem_addr_w] <= mem_data_i;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive this cycle's inputs, then at the falling edge account for both handshakes.
  task automatic half();
    word_t w;
    word_t e;
    logic  wacc;
    logic  rcons;
    logic  lst;
    wr_valid = (src.size() != 0);
    wr_data  = (src.size() != 0) ? src[0].data : '0;
    wr_last  = (src.size() != 0) ? src[0].last : 1'b0;
    rd_ready = rdy;
    @(negedge clk);
    if (!rst) begin
      wacc  = wr_valid && wr_ready;
      rcons = rd_valid && rd_ready;
      if (gap_en && w_inframe && !wacc) wgap++;
      if (gap_en && r_inframe && !rcons) rgap++;
      if (!mem_cen && !wacc) check("park_w", 64'(mem_addr_w[ADDR-2:0]), 64'd255);
      if (rcons) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL rd_unexpected observed=%0h expected=no word", rd_data);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rd_data", 64'(rd_data), 64'(e.data));
          check("rd_last", 64'(rd_last), 64'(e.last));
          r_inframe = !e.last;
          rd_idx = e.last ? 0 : rd_idx + 1;
          if (e.last) frames_done++;
        end
      end
      if (wacc) begin
        w = src.pop_front();
        lst = w.last || (wcnt == MAX_LEN - 1);
        wcnt = lst ? 0 : wcnt + 1;
        w_inframe = !lst;
        e.data = w.data;
        e.last = lst;
        sb.push_back(e);
      end
    end
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    fin();
  endtask

  task automatic push_frame(input logic [7:0] tag, input int len, input logic with_last);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = {tag, 24'(i)};
      w.last = with_last && (i == len - 1);
      src.push_back(w);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (((src.size() != 0) || (sb.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, 64'(src.size() + sb.size()), 64'd0);
  endtask

  task automatic chk_reset_vals();
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
    check("rst_err_ovf", 64'(err_ovf), 64'd0);
    check("rst_cen", 64'(mem_cen), 64'd1);
    check("rst_gwen", 64'(mem_gwen), 64'd1);
    check("rst_addr_r", 64'(mem_addr_r), 64'h0FF);
    check("rst_addr_w", 64'(mem_addr_w), 64'h1FF);
    check("rst_stall_cnt", 64'(wr_stall_cnt), 64'd0);
    check("rst_starve_cnt", 64'(rd_starve_cnt), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    rd_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    half();
    chk_reset_vals();
    fin();
    half();
    check("post_rst_wr_ready", 64'(wr_ready), 64'd1);
    fin();

    // Single 4-word frame: swap bubble, bank flip, then read-only parking.
    push_frame(8'hA0, 4, 1'b1);
    repeat (4) tick();
    half();
    check("swap_cen", 64'(mem_cen), 64'd1);
    check("swap_wr_ready", 64'(wr_ready), 64'd0);
    fin();
    half();
    check("bank_after_swap", 64'(mem_addr_r[ADDR-1]), 64'd1);
    check("first_read_cen", 64'(mem_cen), 64'd0);
    check("first_read_addr_w", 64'(mem_addr_w), 64'h0FF);
    fin();
    drain("drain_a", 100);

    // Four back-to-back 8-word frames with an always-ready consumer.
    gap_en = 1'b1;
    for (int f = 0; f < 4; f++) push_frame(8'h20 + 8'(f), 8, 1'b1);
    drain("drain_b2b", 200);
    gap_en = 1'b0;
    check("wr_gaps", 64'(wgap), 64'd0);
    check("rd_gaps", 64'(rgap), 64'd0);

    // Consumer stalls 10 cycles mid-frame while the producer completes the next frame.
    push_frame(8'h30, 8, 1'b1);
    push_frame(8'h31, 8, 1'b1);
    begin
      int n = 0;
      while ((rd_idx != 3) && (n < 100)) begin
        tick();
        n++;
      end
      check("reach_stall", 64'(rd_idx), 64'd3);
    end
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      half();
      check("stall_valid", 64'(rd_valid), 64'd1);
      check("stall_data", 64'(rd_data), 64'((sb.size() != 0) ? sb[0].data : '0));
      check("stall_addr_r", 64'(mem_addr_r), 64'({1'((frames_done + 1) & 1), 8'(rd_idx)}));
      if (i == 9) begin
        check("wfull_wr_ready", 64'(wr_ready), 64'd0);
        check("wfull_src_done", 64'(src.size()), 64'd0);
      end
      fin();
    end
    rdy = 1'b1;
    drain("drain_stall", 200);

    // Overlong frame: word MAX_LEN is forced last, the leftover joins the next frame.
    check("ovf_before", 64'(err_ovf), 64'd0);
    push_frame(8'h40, 256, 1'b0);
    push_frame(8'h41, 3, 1'b1);
    drain("drain_ovf", 2000);
    check("ovf_sticky", 64'(err_ovf), 64'd1);

    // Reset in the middle of a frame discards it; a fresh frame still goes through.
    push_frame(8'h50, 6, 1'b1);
    repeat (3) tick();
    src.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    wcnt = 0;
    rd_idx = 0;
    frames_done = 0;
    w_inframe = 1'b0;
    r_inframe = 1'b0;
    half();
    chk_reset_vals();
    fin();
    half();
    check("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
    check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    fin();
    push_frame(8'h60, 3, 1'b1);
    drain("drain_after_rst", 100);
    check("ovf_cleared", 64'(err_ovf), 64'd0);
    check("frames_after_rst", 64'(frames_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_pingpong_ctrl.md
Name: dmem_pingpong_ctrl

Overview:
- Scheduler for the PE's two-bank ping-pong data memory (dmem). A producer fills one bank while a consumer drains the other.
- Sequences the memory's shared cen/gwen/addr_r/addr_w/data_i and swaps bank ownership at frame boundaries.
- Sits between the PE datapath producer/consumer streams and dmem; the top level wires its mem_* ports straight to dmem.

Parameters:
- BITS, 32, data word width.
- ADDR, 9, dmem address width. MSB selects the bank. The per-bank depth is 2^(ADDR-1).
- MAX_LEN, 2^(ADDR-1)-1, maximum frame length. The last word of each bank (index 2^(ADDR-1)-1) is a scratch slot.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  producer word valid
- wr_ready  out  1  controller accepts producer word
- wr_data  in  BITS  producer word
- wr_last  in  1  final word of frame
- rd_valid  out  1  consumer word valid
- rd_ready  in  1  consumer accepts word
- rd_data  out  BITS  consumer word (= mem_q)
- rd_last  out  1  final word of frame
- err_ovf  out  1  sticky: frame exceeded MAX_LEN
- wr_stall_cnt  out  16  perf counter (optional feature)
- rd_starve_cnt  out  16  perf counter (optional feature)
- mem_cen  out  1  to dmem cen, active-low
- mem_gwen  out  1  to dmem gwen
- mem_addr_r  out  ADDR  to dmem addr_r
- mem_addr_w  out  ADDR  to dmem addr_w
- mem_data_i  out  BITS  to dmem data_i
- mem_q  in  BITS  from dmem data_o

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Memory rules:
  - mem_gwen is held 1 always, so the read bank reads and the write bank writes.
  - mem_addr_r[ADDR-1] = rd_bank; mem_addr_w[ADDR-1] = ~rd_bank.
  - Every cycle with mem_cen=0 writes mem_data_i at mem_addr_w.
  - In read-only cycles, mem_addr_w low bits park at the scratch index, so no frame data is corrupted.
- Reset values:
  - state=FILL, rd_bank=0, wr_ptr=0, rd_ptr=0, rd_len=0.
  - wr_ready=0 during reset, then 1 the next cycle.
  - rd_valid=0, rd_last=0, err_ovf=0, counters=0, mem_cen=1, mem_addr_*=scratch of respective bank.
- States:
  - FILL: write bank filling, read bank empty.
  - BOTH: filling and draining.
  - WFULL: write frame complete, read draining; wr_ready=0.
  - SWAP: one cycle; mem_cen=1, rd_bank toggles, rd_len<=wr_count, wr_ptr<=0, rd_ptr<=0.
- Transitions:
  - FILL -> SWAP on accepted wr_last.
  - BOTH -> WFULL on accepted wr_last.
  - BOTH -> FILL when the last read word is consumed.
  - WFULL -> SWAP when the last read word is consumed.
  - SWAP -> BOTH.
  - If wr_last is accepted in the same cycle the last read is consumed in BOTH: go -> SWAP.
- Write path:
  - Word accepted on wr_valid&&wr_ready. mem_cen=0, mem_addr_w low = wr_ptr, mem_data_i=wr_data, wr_ptr++.
  - If the accepted word is number MAX_LEN without wr_last: it is treated as last, and err_ovf<=1 (sticky until rst).
- Read path:
  - Read issued when the read bank has words remaining and (!rd_valid || rd_ready). mem_cen=0, mem_addr_r low = rd_ptr, rd_ptr++.
  - rd_valid rises 1 cycle after issue.
  - While stalled, mem_addr_r holds its last issued address, so mem_q stays stable. rd_data = mem_q combinationally.
  - rd_last=1 with the word at index rd_len-1.
- mem_cen=1 when neither a read nor a write is issued.
- Reset mid-frame: all partial frames are discarded; no memory clearing.
- Throughput: 1 write + 1 read per cycle in BOTH. Swap costs 1 bubble.

Optional Feature:
- Macro DMEM_PINGPONG_CTRL_PERF_EN.
- Defined:
  - wr_stall_cnt increments each cycle with wr_valid && !wr_ready.
  - rd_starve_cnt increments each cycle in FILL or SWAP after the first frame.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Package dmem_pingpong_pkg:
  - state enum {FILL, BOTH, WFULL, SWAP}.
  - Function scratch_idx(ADDR).
  - Counter width constant PERF_W=16.
- Optional sub-module dmem_pingpong_perf, holding the saturating counters, instantiated only under the macro.

Test Plan:
- Reset, then a 4-word frame A0..A3 with wr_last -> SWAP at the cycle after A3. The consumer then sees A0..A3 with rd_last on A3, rd_bank=1, mem_cen=1 in the SWAP cycle.
- Back-to-back 8-word frames, rd_ready=1 always -> sustained 1 word/cycle both sides. Exactly one bubble per swap. Data order preserved across 4 frames.
- Consumer holds rd_ready=0 for 10 cycles mid-frame -> rd_data constant, rd_valid=1, mem_addr_r unchanged. Producer finishes its frame and sees wr_ready=0 (WFULL).
- Read-only cycles while the write bank is empty -> mem_addr_w low bits = 255 (ADDR=9). A later frame's word 0 is read back intact.
- 256 words without wr_last (ADDR=9) -> word 255 is forced last, err_ovf=1. The next frame still transfers correctly; err_ovf stays 1 until rst.
- rst asserted mid-frame -> the next cycle shows wr_ready=1, rd_valid=0, state FILL. A new 3-word frame is delivered correctly. With PERF_EN, the counters read 0.
